// File: rtl/wb_commit_unit.sv
// Writeback commit stage: selects the writeback source, performs load reads on the
// data-memory port and issues a registered one-cycle register-file write strobe.
module wb_commit_unit #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      wb_sel,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] ext_imm,
    output logic            mem_arvalid,
    input  logic            mem_arready,
    output logic [AW-1:0]   mem_araddr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          r_state, w_state;
    logic            r_in_ready, w_in_ready;
    logic            r_arvalid, w_arvalid;
    logic [AW-1:0]   r_araddr, w_araddr;
    logic            r_wen, w_wen;
    logic [4:0]      r_waddr, w_waddr;
    logic [XLEN-1:0] r_wdata, w_wdata;
    logic            r_done, w_done;
    logic            r_err, w_err;
    logic [4:0]      r_rd, w_rd;
    logic [2:0]      r_f3, w_f3;
    logic [1:0]      r_off, w_off;

    // Shift the addressed lane down to bit 0, then size and extend it.
    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] off);
        logic [XLEN-1:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  load_extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  load_extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b100:  load_extract = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  load_extract = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

    function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: load_fault = 1'b0;
            3'b001, 3'b101: load_fault = a[0];
            3'b010:         load_fault = (a != 2'b00);
            default:        load_fault = 1'b1;
        endcase
    endfunction

    always_comb begin
        w_state   = r_state;
        w_arvalid = r_arvalid;
        w_araddr  = r_araddr;
        w_wen     = 1'b0;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_waddr   = r_waddr;
        w_wdata   = r_wdata;
        w_rd      = r_rd;
        w_f3      = r_f3;
        w_off     = r_off;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    case (wb_sel)
                        3'b000: begin
                            if (load_fault(funct3, alu_result[1:0])) begin
                                w_done = 1'b1;
                                w_err  = 1'b1;
                            end else begin
                                w_rd      = rd;
                                w_f3      = funct3;
                                w_off     = alu_result[1:0];
                                w_araddr  = {alu_result[AW-1:2], 2'b00};
                                w_arvalid = 1'b1;
                                w_state   = REQ;
                            end
                        end
                        3'b001, 3'b010, 3'b011: begin
                            w_wen   = (rd != 5'd0);
                            w_waddr = rd;
                            w_done  = 1'b1;
                            if (wb_sel == 3'b001)
                                w_wdata = pc + XLEN'(4);
                            else if (wb_sel == 3'b010)
                                w_wdata = alu_result;
                            else
                                w_wdata = ext_imm;
                        end
                        default: begin
                            w_done = 1'b1;
                            w_err  = 1'b1;
                        end
                    endcase
                end
            end
            REQ: begin
                if (mem_arready) begin
                    w_arvalid = 1'b0;
                    w_state   = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    w_wen   = (r_rd != 5'd0);
                    w_waddr = r_rd;
                    w_wdata = load_extract(mem_rdata, r_f3, r_off);
                    w_done  = 1'b1;
                    w_state = IDLE;
                end
            end
            default: begin
                w_arvalid = 1'b0;
                w_state   = IDLE;
            end
        endcase
        w_in_ready = (w_state == IDLE);
    end

    // Single register stage: every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd       <= '0;
            r_f3       <= '0;
            r_off      <= '0;
        end else begin
            r_state    <= w_state;
            r_in_ready <= w_in_ready;
            r_arvalid  <= w_arvalid;
            r_araddr   <= w_araddr;
            r_wen      <= w_wen;
            r_waddr    <= w_waddr;
            r_wdata    <= w_wdata;
            r_done     <= w_done;
            r_err      <= w_err;
            r_rd       <= w_rd;
            r_f3       <= w_f3;
            r_off      <= w_off;
        end
    end

    assign in_ready    = r_in_ready;
    assign mem_arvalid = r_arvalid;
    assign mem_araddr  = r_araddr;
    assign rf_wen      = r_wen;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed-vector bench for wb_commit_unit: table of writeback requests plus
// hand sequences for back-to-back issue, reset mid-load and stray rvalid.
module tb_wb_commit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  wb_sel;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] pc, alu_result, ext_imm;
    logic        mem_arvalid, mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done, err;

    int total  = 0;
    int passed = 0;

    wb_commit_unit #(.XLEN(32), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .wb_sel(wb_sel), .funct3(funct3), .rd(rd),
        .pc(pc), .alu_result(alu_result), .ext_imm(ext_imm),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] imm;
        int          ar_dly;
        int          rv_dly;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic        exp_err;
        logic        exp_mem;
    } vec_t;

    localparam logic [31:0] WORD = 32'h80FF7F01;
    localparam int NV = 19;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [2:0] sel, input logic [2:0] f3, input logic [4:0] r,
                                input logic [31:0] p, input logic [31:0] a, input logic [31:0] im,
                                input int ard, input int rvd, input logic ew,
                                input logic [31:0] ed, input logic ee, input logic em);
        vec_t v;
        v.sel = sel; v.f3 = f3; v.rd = r; v.pc = p; v.alu = a; v.imm = im;
        v.ar_dly = ard; v.rv_dly = rvd; v.exp_wen = ew; v.exp_wdata = ed;
        v.exp_err = ee; v.exp_mem = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Issue one request at the current negedge and follow it to retirement.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc, arcnt, rvcnt, want_lat;
        bit got, saw_arv;
        in_valid = 1'b1; wb_sel = v.sel; funct3 = v.f3; rd = v.rd;
        pc = v.pc; alu_result = v.alu; ext_imm = v.imm; mem_rdata = WORD;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0; arcnt = 0; rvcnt = 0; got = 0; saw_arv = 0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1;
            end else begin
                chk({tag, " busy in_ready"}, 32'(in_ready), 32'd0);
                if (mem_arvalid) begin
                    saw_arv = 1;
                    chk({tag, " araddr"}, mem_araddr, {v.alu[31:2], 2'b00});
                    mem_rvalid = 1'b1;
                    if (arcnt >= v.ar_dly) mem_arready = 1'b1;
                    else begin
                        mem_arready = 1'b0;
                        arcnt++;
                    end
                end else if (saw_arv) begin
                    mem_arready = 1'b0;
                    if (rvcnt >= v.rv_dly) mem_rvalid = 1'b1;
                    else begin
                        mem_rvalid = 1'b0;
                        rvcnt++;
                    end
                end
            end
        end
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        chk({tag, " done"}, 32'(got), 32'd1);
        if (got) begin
            want_lat = v.exp_mem ? (v.ar_dly + v.rv_dly + 3) : 1;
            chk({tag, " latency"}, 32'(cyc), 32'(want_lat));
            chk({tag, " err"}, 32'(err), 32'(v.exp_err));
            chk({tag, " rf_wen"}, 32'(rf_wen), 32'(v.exp_wen));
            chk({tag, " mem access"}, 32'(saw_arv), 32'(v.exp_mem));
            if (!v.exp_err) begin
                chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(v.rd));
                chk({tag, " rf_wdata"}, rf_wdata, v.exp_wdata);
            end
            @(negedge clk);
            chk({tag, " done pulse"}, 32'({done, err, rf_wen}), 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = mk(3'b010, 3'b000, 5'd5,  32'h0,        32'h00001234, 32'h0,        0, 0, 1'b1, 32'h00001234, 1'b0, 1'b0);
        vecs[1]  = mk(3'b001, 3'b000, 5'd1,  32'h80000000, 32'h0,        32'h0,        0, 0, 1'b1, 32'h80000004, 1'b0, 1'b0);
        vecs[2]  = mk(3'b011, 3'b000, 5'd0,  32'h0,        32'h0,        32'hFFFFF000, 0, 0, 1'b0, 32'hFFFFF000, 1'b0, 1'b0);
        vecs[3]  = mk(3'b001, 3'b000, 5'd2,  32'hFFFFFFFC, 32'h0,        32'h0,        0, 0, 1'b1, 32'h00000000, 1'b0, 1'b0);
        vecs[4]  = mk(3'b011, 3'b000, 5'd9,  32'h0,        32'h0,        32'h12345678, 0, 0, 1'b1, 32'h12345678, 1'b0, 1'b0);
        vecs[5]  = mk(3'b000, 3'b000, 5'd7,  32'h0,        32'h80000003, 32'h0,        2, 3, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1);
        vecs[6]  = mk(3'b000, 3'b100, 5'd8,  32'h0,        32'h80000002, 32'h0,        0, 0, 1'b1, 32'h000000FF, 1'b0, 1'b1);
        vecs[7]  = mk(3'b000, 3'b001, 5'd10, 32'h0,        32'h80000000, 32'h0,        1, 0, 1'b1, 32'h00007F01, 1'b0, 1'b1);
        vecs[8]  = mk(3'b000, 3'b101, 5'd11, 32'h0,        32'h80000002, 32'h0,        0, 2, 1'b1, 32'h000080FF, 1'b0, 1'b1);
        vecs[9]  = mk(3'b000, 3'b010, 5'd31, 32'h0,        32'h80000004, 32'h0,        0, 0, 1'b1, 32'h80FF7F01, 1'b0, 1'b1);
        vecs[10] = mk(3'b000, 3'b001, 5'd0,  32'h0,        32'h80000002, 32'h0,        1, 0, 1'b0, 32'hFFFF80FF, 1'b0, 1'b1);
        vecs[11] = mk(3'b000, 3'b000, 5'd12, 32'h0,        32'h80000000, 32'h0,        0, 1, 1'b1, 32'h00000001, 1'b0, 1'b1);
        vecs[12] = mk(3'b000, 3'b100, 5'd13, 32'h0,        32'h80000003, 32'h0,        0, 0, 1'b1, 32'h00000080, 1'b0, 1'b1);
        vecs[13] = mk(3'b000, 3'b010, 5'd4,  32'h0,        32'h80000002, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1, 1'b0);
        vecs[14] = mk(3'b000, 3'b001, 5'd4,  32'h0,        32'h80000001, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1, 1'b0);
        vecs[15] = mk(3'b000, 3'b011, 5'd4,  32'h0,        32'h80000000, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1, 1'b0);
        vecs[16] = mk(3'b111, 3'b000, 5'd4,  32'h0,        32'h80000000, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1, 1'b0);
        vecs[17] = mk(3'b000, 3'b101, 5'd4,  32'h0,        32'h80000003, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1, 1'b0);
        vecs[18] = mk(3'b100, 3'b010, 5'd4,  32'h0,        32'h80000000, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1, 1'b0);

        rst = 1'b1; in_valid = 1'b0; wb_sel = '0; funct3 = '0; rd = '0;
        pc = '0; alu_result = '0; ext_imm = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #3;
        chk("reset outputs", 32'({mem_arvalid, rf_wen, done, err, in_ready}), 32'd0);
        chk("reset rf_wdata", rf_wdata, 32'd0);
        chk("reset araddr", mem_araddr, 32'd0);
        chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", 32'(in_ready), 32'd1);

        // Back-to-back non-load accepts on consecutive edges.
        in_valid = 1'b1; wb_sel = 3'b010; rd = 5'd5; alu_result = 32'h1234;
        @(posedge clk);
        #1 wb_sel = 3'b001; rd = 5'd1; pc = 32'h80000000;
        @(negedge clk);
        chk("b2b first done", 32'({done, rf_wen, err}), 32'b110);
        chk("b2b first waddr", 32'(rf_waddr), 32'd5);
        chk("b2b first wdata", rf_wdata, 32'h1234);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b second done", 32'({done, rf_wen, err}), 32'b110);
        chk("b2b second waddr", 32'(rf_waddr), 32'd1);
        chk("b2b second wdata", rf_wdata, 32'h80000004);
        @(negedge clk);
        chk("b2b idle after", 32'({done, rf_wen}), 32'd0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting for read data abandons the load.
        in_valid = 1'b1; wb_sel = 3'b000; funct3 = 3'b010; rd = 5'd3; alu_result = 32'h80000000;
        @(posedge clk);
        #1 in_valid = 1'b0; mem_arready = 1'b1;
        @(negedge clk);
        chk("abort req arvalid", 32'(mem_arvalid), 32'd1);
        @(posedge clk);
        #1 mem_arready = 1'b0;
        @(negedge clk);
        chk("abort resp arvalid", 32'({mem_arvalid, in_ready}), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid-load reset outputs", 32'({mem_arvalid, rf_wen, done, err}), 32'd0);
        chk("mid-load reset wdata", rf_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            chk($sformatf("post-reset quiet %0d", k), 32'({rf_wen, done, err, mem_arvalid}), 32'd0);
            chk($sformatf("post-reset in_ready %0d", k), 32'(in_ready), 32'd1);
        end

        // Stray rvalid while idle must not retire anything.
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        chk("idle rvalid ignored", 32'({rf_wen, done, err}), 32'd0);
        mem_rvalid = 1'b0;
        run_vec(vecs[9], "after stray rvalid");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Consumer side of the 3-bit writeback-select code produced by the decode stage.
- Accepts one instruction's writeback request and picks the source: pc+4, ALU result, extended immediate, or memory load data.
- For loads it issues a read on the data-memory port, waits for the response, and extracts and extends the loaded byte, halfword or word.
- Commits to the register file with a registered one-cycle write strobe. Sits between execute and the register file in the multi-cycle NPC core.

Parameters:
- XLEN, 32, data and register width.
- AW, 32, memory address width.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  writeback request valid.
- in_ready  output  1  unit can accept a request.
- wb_sel  input  3  000 = memory data, 001 = pc+4, 010 = ALU result, 011 = extended immediate, others illegal.
- funct3  input  3  load width/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- rd  input  5  destination register index.
- pc  input  XLEN  instruction PC.
- alu_result  input  XLEN  ALU output; also the load address when wb_sel = 000.
- ext_imm  input  XLEN  extended immediate.
- mem_arvalid  output  1  read request valid.
- mem_arready  input  1  read request accepted.
- mem_araddr  output  AW  word-aligned read address (low 2 bits zero).
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  XLEN  read data word.
- rf_wen  output  1  register-file write strobe.
- rf_waddr  output  5  register-file write index.
- rf_wdata  output  XLEN  register-file write data.
- done  output  1  one-cycle pulse: request retired (written, suppressed, or faulted).
- err  output  1  one-cycle pulse, coincident with done, for an illegal or misaligned request.

Behaviour:
- Reset (async, rst = 1): state IDLE. mem_arvalid, rf_wen, done and err = 0. rf_waddr, rf_wdata and mem_araddr = 0. in_ready = 1 from the first clock edge after rst deasserts.
- A reset asserted mid-load abandons the transaction. No write occurs and no done pulse is produced.
- States: IDLE, REQ, RESP.
- in_ready = 1 only in IDLE. A request is accepted when in_valid and in_ready are both high at a rising edge (cycle T).
- All outputs are registered.

Non-load requests (wb_sel 001, 010 or 011):
- At T+1: rf_wdata = pc+4 (mod 2^XLEN), alu_result, or ext_imm respectively; rf_waddr = rd; rf_wen = (rd != 0); done = 1.
- State stays IDLE, so back-to-back accepts every cycle are legal.

Illegal wb_sel (1xx):
- At T+1: done = 1, err = 1, rf_wen = 0. No memory access.

Load (wb_sel = 000):
- Checked at T:
  - funct3 not in {000, 001, 010, 100, 101} → fault.
  - lh/lhu with addr[0] = 1 → fault.
  - lw with addr[1:0] != 0 → fault.
- Fault: same response as illegal wb_sel, at T+1.
- Otherwise latch rd, funct3 and addr[1:0], and go to REQ.
- REQ: mem_arvalid = 1 and mem_araddr = {addr[AW-1:2], 00} held stable until the edge where mem_arready = 1; then go to RESP and deassert mem_arvalid.
- RESP: wait for mem_rvalid = 1. mem_rvalid is ignored in every state other than RESP, including the cycle in which mem_arready is sampled.
- On the mem_rvalid edge (cycle R), the shift is by 8×offset, where offset is the latched addr[1:0]:
  - lb/lbu: byte = mem_rdata >> 8×offset; low 8 bits, sign- or zero-extended.
  - lh/lhu: half = mem_rdata >> 8×offset (offset is 0 or 2); low 16 bits, sign- or zero-extended.
  - lw: full word.
- At R+1: rf_wen = (rd != 0), rf_wdata = extracted value, done = 1, state IDLE, in_ready = 1.
- Minimum load latency (accept to write strobe): 3 cycles, with arready = 1 in REQ's first cycle and rvalid in RESP's first cycle.

General:
- rd = 0 is never written; rf_wdata is still driven and done still pulses.
- rf_wen, done and err are high for exactly one cycle per retired request.

Test Plan:
- Reset, then wb_sel = 010, rd = 5, alu_result = 0x1234 → next cycle rf_wen = 1, rf_waddr = 5, rf_wdata = 0x1234, done = 1. Back-to-back wb_sel = 001, pc = 0x80000000, rd = 1 → following cycle rf_wdata = 0x80000004.
- wb_sel = 011, ext_imm = 0xFFFFF000, rd = 0 → rf_wen = 0, done = 1, err = 0.
- lb at addr 0x80000003, mem_rdata = 0x80FF7F01, arready delayed 2 cycles, rvalid delayed 3 cycles:
  - mem_araddr = 0x80000000, held stable while arvalid.
  - rf_wdata = 0xFFFFFF80.
  - in_ready low throughout.
- Same data word with lbu at offset 2 → rf_wdata = 0x000000FF. lh at offset 0 → 0x00007F01. lhu at offset 2 → 0x000080FF. lw → 0x80FF7F01.
- Misaligned lw at 0x80000002, lh at offset 1, and funct3 = 011 → each gives done = err = 1 one cycle later, with no mem_arvalid and rf_wen = 0. wb_sel = 111 → same response.
- Assert rst while in RESP, then pulse mem_rvalid after release → no rf_wen, no done, arvalid = 0, in_ready = 1. A spurious rvalid in IDLE is ignored.
